wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Shares the single register-file write port between the in-order pipeline writeback stage and a long-latency unit (multiply/divide, uncached load) that completes out of order. Keeps a per-register pending scoreboard for long-unit destinations, raises a decode stall on RAW/WAW hazards against pending registers, and steals a writeback slot when the long unit has waited too long. Sits between the writeback stage, the long unit, decode, and the register file; the forwarding unit observes its register-file write outputs.

## Interface
- MAX_WAIT, 4: consecutive ungranted lu_valid cycles before a slot is stolen (2..15).
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  one clock; reset is asynchronous and active-low.
- pipe_write  input  1  writeback stage write request.
- pipe_waddr  input  5  writeback destination.
- pipe_wdata  input  32  writeback data.
- lu_issue  input  1  decode issues a long-unit op this cycle.
- lu_issue_waddr  input  5  its destination.
- lu_valid  input  1  long unit result available.
- lu_waddr  input  5  result destination.
- lu_wdata  input  32  result data.
- lu_ready  output  1  result accepted this cycle.
- dec_raddr1, dec_raddr2  input  5 each  decode source registers.
- dec_write  input  1  decode instruction writes a register via the pipeline.
- dec_waddr  input  5  its destination.
- stall  output  1  freeze fetch/decode this cycle.
- wb_bubble  output  1  writeback stage must present pipe_write=0 next cycle.
- reg_write  output  1  register-file write enable.
- reg_waddr  output  5  register-file write address.
- reg_wdata  output  32  register-file write data.

## Operation
- State: pending[31:1] scoreboard, wait counter (4 bits), FSM {IDLE, WAIT, STEAL}.
- Grant (combinational): pipe_write=1 wins; else lu_valid wins (lu_ready=1). Outputs reg_* mirror the winner; neither → reg_write=0, reg_waddr=0, reg_wdata=0.
- x0: grant with waddr 0 drives reg_write=0; lu_valid with lu_waddr=0 is still acknowledged (lu_ready=1) and discarded.
- stall = pend(dec_raddr1) | pend(dec_raddr2) | (dec_write & pend(dec_waddr)) | (lu_issue & pend(lu_issue_waddr)); pend(0)=0.
- Scoreboard set: lu_issue & ~stall & lu_issue_waddr≠0 sets pending[lu_issue_waddr]. Clear: lu_valid & lu_ready clears pending[lu_waddr]. Same-address set and clear in one cycle: set wins.
- lu_valid to a non-pending register: still granted normally; scoreboard unchanged.
- FSM: IDLE→WAIT when lu_valid & ~lu_ready (counter=1). WAIT: counter increments each cycle lu_valid & ~lu_ready; lu_ready or ~lu_valid → IDLE, counter=0; counter reaching MAX_WAIT → STEAL. STEAL: wb_bubble=1, stall=1; leaves to IDLE when lu_ready=1 or lu_valid=0. If pipe_write is still 1 in STEAL, pipeline wins and FSM stays in STEAL.
- wb_bubble=0 in IDLE and WAIT.

## Timing
- Reset (async, reset_n=0): pending all 0, counter 0, FSM IDLE; outputs then follow combinational rules (stall=0, wb_bubble=0, reg_write=0 absent requests). Reset mid-steal drops to IDLE immediately; lost pending bits are the system's concern.
- Grant, lu_ready, reg_* and stall are same-cycle combinational; register-file write commits on the next rising edge.
- Scoreboard effect is one-cycle: a register is pending from the cycle after issue until the cycle after its result is acknowledged; decode sees stall drop the cycle after lu_ready.
- Steal latency: lu_valid held with pipe_write=1 every cycle → STEAL entered after MAX_WAIT cycles, wb_bubble asserted in cycle MAX_WAIT+1, grant at latest cycle MAX_WAIT+2 given a compliant pipeline.

## Test plan
- Reset, no requests -> stall=0, wb_bubble=0, reg_write=0, lu_ready=0.
- pipe_write x5=0x11 with lu_valid x6=0x22 same cycle -> reg_waddr=5, reg_wdata=0x11, lu_ready=0; next cycle pipe_write=0 -> reg_waddr=6, lu_ready=1.
- lu_issue x7, next cycle dec_raddr1=7 -> stall=1 until cycle after lu_valid x7 acknowledged, then stall=0; dec_raddr1=0 never stalls.
- lu_issue x9 then lu_issue x9 again -> second issue stalled (WAW), pending[9] stays 1.
- MAX_WAIT=4, pipe_write=1 and lu_valid=1 continuously -> wb_bubble=1 in cycle 5; pipe_write dropped in cycle 6 -> lu_ready=1, FSM IDLE.
- lu_valid x0 data 0xFF -> lu_ready=1, reg_write=0; reset_n pulsed low in STEAL -> wb_bubble=0 immediately, pending cleared.

Source files
------------

// File: rtl/wb_arbiter.sv
//------------------------------------------------------------------------------
// Module   : wb_arbiter
// Brief    : Register-file write-port arbiter between the writeback stage and
//            an out-of-order long-latency unit, with a pending scoreboard that
//            stalls decode on hazards and a starvation-driven writeback steal.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pipe_write,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  input  logic        lu_issue,
  input  logic [4:0]  lu_issue_waddr,
  input  logic        lu_valid,
  input  logic [4:0]  lu_waddr,
  input  logic [31:0] lu_wdata,
  output logic        lu_ready,
  input  logic [4:0]  dec_raddr1,
  input  logic [4:0]  dec_raddr2,
  input  logic        dec_write,
  input  logic [4:0]  dec_waddr,
  output logic        stall,
  output logic        wb_bubble,
  output logic        reg_write,
  output logic [4:0]  reg_waddr,
  output logic [31:0] reg_wdata
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_wait  = 2'd1;
  localparam logic [1:0] c_st_steal = 2'd2;

  localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

  logic [31:0] r_pending;
  logic [31:0] w_pending_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [3:0]  w_cnt_inc;
  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        w_lu_starved;
  logic        w_hazard;

  // Register 0 is never pending, so bit 0 of the scoreboard is held at zero.
  function automatic logic pend(input logic [31:0] sb, input logic [4:0] a);
    return (a != 5'd0) && sb[a];
  endfunction

  // Pipeline always wins the port; the long unit only gets an idle slot.
  always_comb begin
    lu_ready  = 1'b0;
    reg_write = 1'b0;
    reg_waddr = 5'd0;
    reg_wdata = 32'd0;
    if (pipe_write) begin
      reg_write = (pipe_waddr != 5'd0);
      reg_waddr = pipe_waddr;
      reg_wdata = pipe_wdata;
    end else if (lu_valid) begin
      lu_ready  = 1'b1;
      reg_write = (lu_waddr != 5'd0);
      reg_waddr = lu_waddr;
      reg_wdata = lu_wdata;
    end
  end

  assign w_hazard = pend(r_pending, dec_raddr1)
                  | pend(r_pending, dec_raddr2)
                  | (dec_write & pend(r_pending, dec_waddr))
                  | (lu_issue & pend(r_pending, lu_issue_waddr));

  assign stall     = w_hazard | (r_state == c_st_steal);
  assign wb_bubble = (r_state == c_st_steal);

  // Set is applied after clear so a same-address issue in the ack cycle wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (lu_valid && lu_ready) begin
      w_pending_nxt[lu_waddr] = 1'b0;
    end
    if (lu_issue && !stall && (lu_issue_waddr != 5'd0)) begin
      w_pending_nxt[lu_issue_waddr] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  assign w_lu_starved = lu_valid & ~lu_ready;
  assign w_cnt_inc    = r_cnt + 4'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      c_st_idle: begin
        if (w_lu_starved) begin
          w_state_nxt = c_st_wait;
          w_cnt_nxt   = 4'd1;
        end
      end
      c_st_wait: begin
        if (!w_lu_starved) begin
          w_state_nxt = c_st_idle;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc >= c_max_wait) begin
            w_state_nxt = c_st_steal;
          end
        end
      end
      c_st_steal: begin
        if (!w_lu_starved) begin
          w_state_nxt = c_st_idle;
          w_cnt_nxt   = 4'd0;
        end
      end
      default: begin
        w_state_nxt = c_st_idle;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= 32'd0;
      r_cnt     <= 4'd0;
      r_state   <= c_st_idle;
    end else begin
      r_pending <= w_pending_nxt;
      r_cnt     <= w_cnt_nxt;
      r_state   <= w_state_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_wb_arbiter
// Brief    : Directed self-checking bench for wb_arbiter using an expectation
//            queue popped at each sample point.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pipe_write;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        lu_issue;
  logic [4:0]  lu_issue_waddr;
  logic        lu_valid;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        lu_ready;
  logic [4:0]  dec_raddr1;
  logic [4:0]  dec_raddr2;
  logic        dec_write;
  logic [4:0]  dec_waddr;
  logic        stall;
  logic        wb_bubble;
  logic        reg_write;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;

  typedef struct {
    string       tag;
    logic        lu_ready;
    logic        reg_write;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        stall;
    logic        wb_bubble;
  } exp_t;

  exp_t q_exp[$];
  int   n_pass  = 0;
  int   n_total = 0;

  wb_arbiter #(.MAX_WAIT(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pipe_write     (pipe_write),
    .pipe_waddr     (pipe_waddr),
    .pipe_wdata     (pipe_wdata),
    .lu_issue       (lu_issue),
    .lu_issue_waddr (lu_issue_waddr),
    .lu_valid       (lu_valid),
    .lu_waddr       (lu_waddr),
    .lu_wdata       (lu_wdata),
    .lu_ready       (lu_ready),
    .dec_raddr1     (dec_raddr1),
    .dec_raddr2     (dec_raddr2),
    .dec_write      (dec_write),
    .dec_waddr      (dec_waddr),
    .stall          (stall),
    .wb_bubble      (wb_bubble),
    .reg_write      (reg_write),
    .reg_waddr      (reg_waddr),
    .reg_wdata      (reg_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    pipe_write = 1'b0; pipe_waddr = 5'd0; pipe_wdata = 32'd0;
    lu_issue = 1'b0; lu_issue_waddr = 5'd0;
    lu_valid = 1'b0; lu_waddr = 5'd0; lu_wdata = 32'd0;
    dec_raddr1 = 5'd0; dec_raddr2 = 5'd0; dec_write = 1'b0; dec_waddr = 5'd0;
  endtask

  task automatic push(input string tag, input logic rdy, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd,
                      input logic st, input logic bub);
    exp_t e;
    e.tag = tag; e.lu_ready = rdy; e.reg_write = we; e.reg_waddr = wa;
    e.reg_wdata = wd; e.stall = st; e.wb_bubble = bub;
    q_exp.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic check_out();
    exp_t e;
    if (q_exp.size() == 0) begin
      n_total++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = q_exp.pop_front();
      chk({e.tag, ".lu_ready"},  32'(lu_ready),  32'(e.lu_ready));
      chk({e.tag, ".reg_write"}, 32'(reg_write), 32'(e.reg_write));
      chk({e.tag, ".reg_waddr"}, 32'(reg_waddr), 32'(e.reg_waddr));
      chk({e.tag, ".reg_wdata"}, reg_wdata,      e.reg_wdata);
      chk({e.tag, ".stall"},     32'(stall),     32'(e.stall));
      chk({e.tag, ".wb_bubble"}, 32'(wb_bubble), 32'(e.wb_bubble));
    end
  endtask

  // Inputs are already driven; sample at the falling edge, then advance.
  task automatic cyc(input string tag, input logic rdy, input logic we,
                     input logic [4:0] wa, input logic [31:0] wd,
                     input logic st, input logic bub);
    push(tag, rdy, we, wa, wd, st, bub);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push("reset", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc("post_reset", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

    // Simultaneous requests: pipeline first, long unit next cycle.
    pipe_write = 1; pipe_waddr = 5; pipe_wdata = 32'h11;
    lu_valid = 1; lu_waddr = 6; lu_wdata = 32'h22;
    cyc("both_req", 1'b0, 1'b1, 5'd5, 32'h11, 1'b0, 1'b0);
    pipe_write = 0;
    cyc("lu_grant", 1'b1, 1'b1, 5'd6, 32'h22, 1'b0, 1'b0);

    // RAW on x7.
    idle_inputs(); lu_issue = 1; lu_issue_waddr = 7;
    cyc("issue_x7", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    idle_inputs(); dec_raddr1 = 7;
    cyc("raw_x7", 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    lu_valid = 1; lu_waddr = 7; lu_wdata = 32'h77;
    cyc("ack_x7", 1'b1, 1'b1, 5'd7, 32'h77, 1'b1, 1'b0);
    idle_inputs(); dec_raddr1 = 7;
    cyc("x7_released", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    dec_raddr1 = 0; dec_raddr2 = 0; dec_write = 1; dec_waddr = 0;
    cyc("x0_nostall", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

    // WAW on x9: second issue stalls and must not disturb pending[9].
    idle_inputs(); lu_issue = 1; lu_issue_waddr = 9;
    cyc("issue_x9", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    cyc("waw_x9", 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    idle_inputs(); dec_write = 1; dec_waddr = 9;
    cyc("dec_waw_x9", 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    idle_inputs(); lu_valid = 1; lu_waddr = 9; lu_wdata = 32'h99;
    cyc("ack_x9", 1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 1'b0);
    idle_inputs(); dec_raddr2 = 9;
    cyc("x9_released", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

    // Ack of non-pending x11 coincides with a new issue to x11: set wins.
    idle_inputs(); lu_valid = 1; lu_waddr = 11; lu_wdata = 32'hB1;
    lu_issue = 1; lu_issue_waddr = 11;
    cyc("set_clear_x11", 1'b1, 1'b1, 5'd11, 32'hB1, 1'b0, 1'b0);
    idle_inputs(); dec_raddr1 = 11;
    cyc("x11_pending", 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    lu_valid = 1; lu_waddr = 11; lu_wdata = 32'hB2;
    cyc("ack_x11", 1'b1, 1'b1, 5'd11, 32'hB2, 1'b1, 1'b0);
    idle_inputs(); dec_raddr1 = 11;
    cyc("x11_released", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

    // Starvation: STEAL after MAX_WAIT cycles, bubble in cycle 5.
    idle_inputs();
    pipe_write = 1; pipe_waddr = 3; pipe_wdata = 32'h33;
    lu_valid = 1; lu_waddr = 4; lu_wdata = 32'h44;
    for (int i = 1; i <= 4; i++)
      cyc($sformatf("starve_c%0d", i), 1'b0, 1'b1, 5'd3, 32'h33, 1'b0, 1'b0);
    cyc("steal_c5", 1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 1'b1);
    pipe_write = 0;
    cyc("steal_c6", 1'b1, 1'b1, 5'd4, 32'h44, 1'b1, 1'b1);
    idle_inputs();
    cyc("steal_exit", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

    // x0 result acknowledged but not written; also mark x12 pending.
    lu_valid = 1; lu_waddr = 0; lu_wdata = 32'hFF;
    lu_issue = 1; lu_issue_waddr = 12;
    cyc("lu_x0", 1'b1, 1'b0, 5'd0, 32'hFF, 1'b0, 1'b0);
    idle_inputs(); dec_raddr2 = 12;
    cyc("x12_pending", 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);

    // Enter STEAL again, then assert reset mid-cycle.
    idle_inputs();
    pipe_write = 1; pipe_waddr = 1; pipe_wdata = 32'h01;
    lu_valid = 1; lu_waddr = 2; lu_wdata = 32'h02;
    for (int i = 1; i <= 4; i++)
      cyc($sformatf("restarve_c%0d", i), 1'b0, 1'b1, 5'd1, 32'h01, 1'b0, 1'b0);
    push("resteal", 1'b0, 1'b1, 5'd1, 32'h01, 1'b1, 1'b1);
    @(negedge clk);
    check_out();
    #1 reset_n = 1'b0;
    #1;
    push("reset_in_steal", 1'b0, 1'b1, 5'd1, 32'h01, 1'b0, 1'b0);
    check_out();
    idle_inputs(); dec_raddr1 = 12;
    #1;
    push("reset_pending_clr", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check_out();
    @(posedge clk);
    #1 reset_n = 1'b1;
    cyc("after_reset_x12", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

    if (q_exp.size() != 0) begin
      n_total++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", q_exp.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
